ysyx_22040383_pipe_stage: RTL and testbench

//  Generic parametrised pipeline register replacing per-stage hand-written regs (ex/mem etc.).

---
 rtl/ysyx_22040383_pipe_stage_if.sv | 12 +
 rtl/ysyx_22040383_pipe_stage.sv | 98 +++++++++
 tb/tb_ysyx_22040383_pipe_stage.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040383_pipe_stage_if.sv
// Valid/ready payload channel between two pipeline stages.
// The producer uses the master modport and the consumer uses the slave modport.
interface ysyx_22040383_pipe_stage_if #(
    parameter int unsigned DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ysyx_22040383_pipe_stage.sv
// Generic pipeline register: valid/ready payload stage with an optional skid entry,
// synchronous flush and a saturating back-pressure counter.
module ysyx_22040383_pipe_stage #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       flush,
    ysyx_22040383_pipe_stage_if.slave  up,
    ysyx_22040383_pipe_stage_if.master dn,
    output logic [1:0]                 occupancy,
    output logic [CNT_W-1:0]           stall_cnt
);
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              in_ready_q, in_ready_d;
    logic              in_ready, out_valid, accept, pop;

    assign out_valid = (state_q != StEmpty);
    // Without the skid entry, a full stage may only accept when it drains the same cycle.
    assign in_ready  = (SKID != 0) ? in_ready_q : (dn.ready | ~out_valid);
    assign accept    = up.valid & in_ready;
    assign pop       = out_valid & dn.ready;

    assign up.ready  = in_ready;
    assign dn.valid  = out_valid;
    assign dn.data   = main_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        stall_d = stall_q;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    main_d  = up.data;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (accept && pop) begin
                    main_d = up.data;
                end else if (accept) begin
                    skid_d  = up.data;
                    state_d = StFull;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush drops every held entry; payload registers keep their stale contents.
        if (flush) begin
            state_d = StEmpty;
            main_d  = main_q;
            skid_d  = skid_q;
        end
        if (out_valid && !dn.ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
        in_ready_d = (state_d != StFull);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= StEmpty;
            main_q     <= '0;
            skid_q     <= '0;
            stall_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            stall_q    <= stall_d;
            in_ready_q <= in_ready_d;
        end
    end
endmodule

// File: tb/tb_ysyx_22040383_pipe_stage.sv
// Bench for the pipeline stage: a skid instance (CNT_W=3) and a no-skid instance,
// checked every cycle against queue-based models plus directed literal expectations.
module tb_ysyx_22040383_pipe_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  occ_a, occ_b;
    logic [2:0]  stall_a;
    logic [15:0] stall_b;
    int          n_tests = 0;
    int          n_fail  = 0;

    ysyx_22040383_pipe_stage_if #(.DATA_W(8)) a_in ();
    ysyx_22040383_pipe_stage_if #(.DATA_W(8)) a_out ();
    ysyx_22040383_pipe_stage_if #(.DATA_W(8)) b_in ();
    ysyx_22040383_pipe_stage_if #(.DATA_W(8)) b_out ();

    ysyx_22040383_pipe_stage #(.DATA_W(8), .SKID(1), .CNT_W(3)) u_a (
        .sys_clk(clk), .sys_rst(rst), .flush(flush), .up(a_in), .dn(a_out),
        .occupancy(occ_a), .stall_cnt(stall_a)
    );
    ysyx_22040383_pipe_stage #(.DATA_W(8), .SKID(0), .CNT_W(16)) u_b (
        .sys_clk(clk), .sys_rst(rst), .flush(flush), .up(b_in), .dn(b_out),
        .occupancy(occ_b), .stall_cnt(stall_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Models: a stage is a FIFO of capacity 2 (skid) or 1 (no skid).
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int unsigned sa = 0, sb = 0;
    bit armed = 1'b0;

    always @(posedge clk) begin : model
        bit acc, pop;
        if (rst) begin
            qa.delete();
            qb.delete();
            sa = 0;
            sb = 0;
            armed = 1'b1;
        end else begin
            acc = a_in.valid && (qa.size() != 2);
            pop = (qa.size() != 0) && a_out.ready;
            if (qa.size() != 0 && !a_out.ready && sa != 7) sa++;
            if (pop) void'(qa.pop_front());
            if (flush) qa.delete();
            else if (acc) qa.push_back(a_in.data);

            acc = b_in.valid && (b_out.ready || qb.size() == 0);
            pop = (qb.size() != 0) && b_out.ready;
            if (qb.size() != 0 && !b_out.ready && sb != 65535) sb++;
            if (pop) void'(qb.pop_front());
            if (flush) qb.delete();
            else if (acc) qb.push_back(b_in.data);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("a_in_ready", a_in.ready, qa.size() != 2);
            chk("a_out_valid", a_out.valid, qa.size() != 0);
            chk("a_occ", occ_a, qa.size());
            chk("a_stall", stall_a, sa);
            if (qa.size() != 0) chk("a_out_data", a_out.data, qa[0]);
            chk("b_in_ready", b_in.ready, b_out.ready || qb.size() == 0);
            chk("b_out_valid", b_out.valid, qb.size() != 0);
            chk("b_occ", occ_b, qb.size());
            chk("b_occ_le1", occ_b <= 2'd1, 1);
            chk("b_stall", stall_b, sb);
            if (qb.size() != 0) chk("b_out_data", b_out.data, qb[0]);
        end
    end

    initial begin
        logic [7:0] vals [3];
        vals[0] = 8'h11;
        vals[1] = 8'h22;
        vals[2] = 8'h33;

        // Reset held two cycles with upstream valid asserted.
        rst = 1'b1;
        flush = 1'b0;
        a_in.valid = 1'b1;  a_in.data = 8'h55;  a_out.ready = 1'b0;
        b_in.valid = 1'b1;  b_in.data = 8'h55;  b_out.ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        a_in.valid = 1'b0;
        b_in.valid = 1'b0;
        chk("rst_a_valid", a_out.valid, 0);
        chk("rst_a_data", a_out.data, 0);
        chk("rst_a_occ", occ_a, 0);
        chk("rst_a_stall", stall_a, 0);
        chk("rst_a_in_ready", a_in.ready, 1);
        chk("rst_b_valid", b_out.valid, 0);
        chk("rst_b_data", b_out.data, 0);
        chk("rst_b_stall", stall_b, 0);

        // Streaming, no bubbles.
        a_out.ready = 1'b1;
        b_out.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in.valid = 1'b1;  a_in.data = vals[i];
            b_in.valid = 1'b1;  b_in.data = vals[i];
            tick();
            chk("stream_a_valid", a_out.valid, 1);
            chk("stream_a_data", a_out.data, vals[i]);
            chk("stream_b_data", b_out.data, vals[i]);
        end
        a_in.valid = 1'b0;
        b_in.valid = 1'b0;
        tick();
        chk("stream_a_drained", a_out.valid, 0);
        chk("stream_b_drained", b_out.valid, 0);

        // Back-pressure on the skid stage.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_out.ready = 1'b0;
        a_in.valid = 1'b1;  a_in.data = 8'h0A;
        tick();
        chk("bp_occ1", occ_a, 1);
        a_in.data = 8'h0B;
        tick();
        chk("bp_occ2", occ_a, 2);
        chk("bp_in_ready0", a_in.ready, 0);
        chk("bp_stall1", stall_a, 1);
        a_in.data = 8'h0C;
        tick();
        tick();
        chk("bp_held_occ", occ_a, 2);
        chk("bp_head", a_out.data, 8'h0A);
        chk("bp_stall3", stall_a, 3);
        a_out.ready = 1'b1;
        tick();
        chk("bp_out_b", a_out.data, 8'h0B);
        chk("bp_in_ready1", a_in.ready, 1);
        tick();
        chk("bp_out_c", a_out.data, 8'h0C);
        chk("bp_occ_c", occ_a, 1);
        a_in.valid = 1'b0;
        tick();
        chk("bp_empty", a_out.valid, 0);
        chk("bp_stall_final", stall_a, 3);

        // Flush with a same-edge upstream payload.
        a_out.ready = 1'b0;
        a_in.valid = 1'b1;  a_in.data = 8'h01;
        b_in.valid = 1'b1;  b_in.data = 8'h03;
        tick();
        a_in.data = 8'h02;
        b_in.valid = 1'b0;
        tick();
        chk("fl_pre_occ", occ_a, 2);
        a_in.data = 8'h0D;
        b_in.valid = 1'b1;  b_in.data = 8'h0D;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        a_in.valid = 1'b0;
        b_in.valid = 1'b0;
        chk("fl_a_occ", occ_a, 0);
        chk("fl_a_valid", a_out.valid, 0);
        chk("fl_a_in_ready", a_in.ready, 1);
        chk("fl_b_valid", b_out.valid, 0);
        chk("fl_stall_kept", stall_a, 5);
        a_out.ready = 1'b1;
        tick();
        tick();
        chk("fl_a_no_d", a_out.valid, 0);
        chk("fl_b_no_d", b_out.valid, 0);

        // Saturation of the 3-bit counter.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_out.ready = 1'b0;
        a_in.valid = 1'b1;  a_in.data = 8'h05;
        tick();
        a_in.valid = 1'b0;
        repeat (10) tick();
        chk("sat_stall", stall_a, 7);
        chk("sat_head", a_out.data, 8'h05);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("sat_after_flush", stall_a, 7);

        // Random traffic on both stages, rare flushes.
        for (int i = 0; i < 1000; i++) begin
            a_in.valid  = 1'($urandom_range(0, 1));
            a_in.data   = 8'($urandom);
            a_out.ready = 1'($urandom_range(0, 1));
            b_in.valid  = 1'($urandom_range(0, 1));
            b_in.data   = 8'($urandom);
            b_out.ready = 1'($urandom_range(0, 1));
            flush       = ($urandom_range(0, 63) == 0);
            tick();
        end
        a_in.valid = 1'b0;
        b_in.valid = 1'b0;
        a_out.ready = 1'b1;
        b_out.ready = 1'b1;
        flush = 1'b0;
        repeat (4) tick();
        chk("rand_a_drained", a_out.valid, 0);
        chk("rand_b_drained", b_out.valid, 0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
